// File: rtl/code_entry_buffer_pkg.sv
// Shared types and constants for the keypad code entry buffer.
// Imported by the top and the idle-timer sub-module.
package code_entry_buffer_pkg;

    typedef enum logic {
        ST_ENTRY = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    localparam int DIGIT_W_DEF    = 4;
    localparam int OVERFLOW_DROP  = 0;
    localparam int OVERFLOW_SHIFT = 1;

    function automatic int cnt_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/code_entry_buffer_idle_timer.sv
// Idle counter: counts cycles while run is high and no restart occurs,
// pulses expire on the cycle it reaches TIMEOUT_CYC-1.
module entry_idle_timer
    import code_entry_buffer_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic restart,
    output logic expire
);

    localparam int CW = cnt_width(TIMEOUT_CYC);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (TIMEOUT_CYC == 0 || restart || !run) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            expire = 1'b1;
            cnt_d  = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/code_entry_buffer.sv
// Variable-length keypad code collector with backspace, clear, idle
// timeout and overflow policy; hands the code off over valid/ack.
module code_entry_buffer
    import code_entry_buffer_pkg::*;
#(
    parameter int DIGIT_W       = DIGIT_W_DEF,
    parameter int MAX_LEN       = 8,
    parameter int MIN_LEN       = 4,
    parameter int TIMEOUT_CYC   = 1000,
    parameter int OVERFLOW_MODE = OVERFLOW_DROP
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         digit_valid,
    input  logic [DIGIT_W-1:0]           digit_in,
    input  logic                         backspace,
    input  logic                         clear,
    input  logic                         submit,
    input  logic                         code_ack,
    output logic [MAX_LEN*DIGIT_W-1:0]   code_out,
    output logic [$clog2(MAX_LEN+1)-1:0] code_len,
    output logic                         code_valid,
    output logic                         ready,
    output logic                         full,
    output logic                         err,
    output logic                         timeout
);

    localparam int BW = MAX_LEN * DIGIT_W;
    localparam int LW = $clog2(MAX_LEN + 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   buf_q, buf_d;
    logic [LW-1:0]   len_q, len_d;
    logic            err_q, err_d;
    logic            to_q, to_d;
    logic            run, restart, expire;

    wire in_entry = (state_q == ST_ENTRY);
    wire has_min  = (len_q >= LW'(MIN_LEN));
    wire is_full  = (len_q == LW'(MAX_LEN));

    assign run     = in_entry && (len_q != '0);
    assign restart = in_entry &&
                     (clear || submit || backspace || digit_valid);

    entry_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .restart (restart),
        .expire  (expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_ENTRY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_ENTRY: if (!clear && submit && has_min) state_d = ST_HOLD;
            ST_HOLD:  if (code_ack || clear)           state_d = ST_ENTRY;
            default:  state_d = ST_ENTRY;
        endcase
    end

    always_comb begin
        code_valid = (state_q == ST_HOLD);
        ready      = in_entry;
    end

    // Full buffer in shift mode reuses the append path; only len is held.
    always_comb begin
        buf_d = buf_q;
        len_d = len_q;
        err_d = 1'b0;
        to_d  = 1'b0;
        unique case (state_q)
            ST_ENTRY: begin
                if (clear) begin
                    buf_d = '0;
                    len_d = '0;
                end else if (submit) begin
                    err_d = !has_min;
                end else if (backspace) begin
                    if (len_q != '0) begin
                        buf_d = buf_q >> DIGIT_W;
                        len_d = len_q - 1'b1;
                    end
                end else if (digit_valid) begin
                    if (!is_full) begin
                        buf_d = (buf_q << DIGIT_W) | BW'(digit_in);
                        len_d = len_q + 1'b1;
                    end else if (OVERFLOW_MODE == OVERFLOW_DROP) begin
                        err_d = 1'b1;
                    end else begin
                        buf_d = (buf_q << DIGIT_W) | BW'(digit_in);
                    end
                end else if (expire) begin
                    buf_d = '0;
                    len_d = '0;
                    to_d  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (code_ack || clear) begin
                    buf_d = '0;
                    len_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q <= '0;
            len_q <= '0;
            err_q <= 1'b0;
            to_q  <= 1'b0;
        end else begin
            buf_q <= buf_d;
            len_q <= len_d;
            err_q <= err_d;
            to_q  <= to_d;
        end
    end

    assign code_out = buf_q;
    assign code_len = len_q;
    assign full     = is_full;
    assign err      = err_q;
    assign timeout  = to_q;

endmodule

// File: tb/tb_code_entry_buffer.sv
// Bench: three instances (drop T=16, shift T=16, drop T=0) driven in
// lockstep and compared against a digit-list reference model.
module tb_code_entry_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dv = 1'b0, bs = 1'b0, clr = 1'b0, sub = 1'b0, ack = 1'b0;
    logic [3:0] din = 4'h0;

    logic [31:0] cout [3];
    logic [3:0]  clen [3];
    logic        cval [3], rdy [3], ful [3], er [3], tmo [3];

    int vectors = 0;
    int miscompares = 0;

    int dig   [3][8];
    int len   [3];
    bit hold  [3];
    int idle  [3];
    bit errx  [3];
    bit tox   [3];
    int mmode [3] = '{0, 1, 0};
    int mtmo  [3] = '{16, 16, 0};

    always #5 clk = ~clk;

    code_entry_buffer #(.DIGIT_W(4), .MAX_LEN(8), .MIN_LEN(4),
        .TIMEOUT_CYC(16), .OVERFLOW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .digit_valid(dv), .digit_in(din),
        .backspace(bs), .clear(clr), .submit(sub), .code_ack(ack),
        .code_out(cout[0]), .code_len(clen[0]), .code_valid(cval[0]),
        .ready(rdy[0]), .full(ful[0]), .err(er[0]), .timeout(tmo[0]));

    code_entry_buffer #(.DIGIT_W(4), .MAX_LEN(8), .MIN_LEN(4),
        .TIMEOUT_CYC(16), .OVERFLOW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .digit_valid(dv), .digit_in(din),
        .backspace(bs), .clear(clr), .submit(sub), .code_ack(ack),
        .code_out(cout[1]), .code_len(clen[1]), .code_valid(cval[1]),
        .ready(rdy[1]), .full(ful[1]), .err(er[1]), .timeout(tmo[1]));

    code_entry_buffer #(.DIGIT_W(4), .MAX_LEN(8), .MIN_LEN(4),
        .TIMEOUT_CYC(0), .OVERFLOW_MODE(0)) dut2 (
        .clk(clk), .rst(rst), .digit_valid(dv), .digit_in(din),
        .backspace(bs), .clear(clr), .submit(sub), .code_ack(ack),
        .code_out(cout[2]), .code_len(clen[2]), .code_valid(cval[2]),
        .ready(rdy[2]), .full(ful[2]), .err(er[2]), .timeout(tmo[2]));

    function automatic void mreset();
        for (int m = 0; m < 3; m++) begin
            len[m] = 0; hold[m] = 0; idle[m] = 0;
            errx[m] = 0; tox[m] = 0;
        end
    endfunction

    function automatic void mstep(int m);
        errx[m] = 0;
        tox[m]  = 0;
        if (hold[m]) begin
            if (ack || clr) begin
                hold[m] = 0;
                len[m]  = 0;
            end
            idle[m] = 0;
        end else begin
            if (clr) len[m] = 0;
            else if (sub) begin
                if (len[m] >= 4) hold[m] = 1;
                else errx[m] = 1;
            end else if (bs) begin
                if (len[m] > 0) len[m]--;
            end else if (dv) begin
                if (len[m] < 8) begin
                    dig[m][len[m]] = int'(din);
                    len[m]++;
                end else if (mmode[m] == 0) errx[m] = 1;
                else begin
                    for (int i = 0; i < 7; i++) dig[m][i] = dig[m][i+1];
                    dig[m][7] = int'(din);
                end
            end
            if (clr || sub || bs || dv) idle[m] = 0;
            else if (len[m] > 0 && mtmo[m] > 0) begin
                idle[m]++;
                if (idle[m] == mtmo[m]) begin
                    len[m] = 0; idle[m] = 0; tox[m] = 1;
                end
            end
        end
    endfunction

    function automatic logic [40:0] mexp(int m);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < len[m]; i++) v = (v << 4) | 32'(dig[m][i]);
        return {v, 4'(len[m]), hold[m], !hold[m], len[m] == 8,
                errx[m], tox[m]};
    endfunction

    task automatic check_all();
        logic [40:0] obs, ex;
        for (int m = 0; m < 3; m++) begin
            obs = {cout[m], clen[m], cval[m], rdy[m], ful[m], er[m], tmo[m]};
            ex  = mexp(m);
            vectors++;
            assert (obs === ex) else begin
                miscompares++;
                $error("FAIL dut%0d state obs=%h exp=%h", m, obs, ex);
            end
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] ex);
        vectors++;
        assert (obs === ex) else begin
            miscompares++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, ex);
        end
    endtask

    task automatic cyc(bit c, bit s, bit b, bit d, logic [3:0] v, bit a);
        clr = c; sub = s; bs = b; dv = d; din = v; ack = a;
        @(posedge clk);
        for (int m = 0; m < 3; m++) mstep(m);
        #1;
        check_all();
    endtask

    task automatic key(logic [3:0] v);
        cyc(0, 0, 0, 1, v, 0);
    endtask

    task automatic idle_n(int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 4'h0, 0);
    endtask

    initial begin
        mreset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;
        idle_n(1);

        // Four digits, submit, acknowledge
        for (int i = 1; i <= 4; i++) key(4'(i));
        cyc(0, 1, 0, 0, 4'h0, 0);
        chk("t1_code", cout[0], 32'h0000_1234);
        chk("t1_valid", {31'h0, cval[0]}, 32'h1);
        chk("t1_ready", {31'h0, rdy[0]}, 32'h0);
        cyc(0, 0, 0, 0, 4'h0, 1);
        chk("t1_ack_len", {28'h0, clen[0]}, 32'h0);
        chk("t1_ack_ready", {31'h0, rdy[0]}, 32'h1);

        // Short submit, then digit and backspace
        for (int i = 1; i <= 3; i++) key(4'(i));
        cyc(0, 1, 0, 0, 4'h0, 0);
        chk("t2_err", {31'h0, er[0]}, 32'h1);
        chk("t2_code", cout[0], 32'h123);
        idle_n(1);
        chk("t2_err_gone", {31'h0, er[0]}, 32'h0);
        key(4'h9);
        cyc(0, 0, 1, 0, 4'h0, 0);
        chk("t2_bs", cout[0], 32'h123);
        cyc(1, 0, 0, 0, 4'h0, 0);
        cyc(0, 0, 1, 0, 4'h0, 0);

        // Overflow: drop vs shift
        for (int i = 1; i <= 9; i++) key(4'(i));
        chk("t3_drop", cout[0], 32'h1234_5678);
        chk("t3_drop_err", {31'h0, er[0]}, 32'h1);
        chk("t3_shift", cout[1], 32'h2345_6789);
        chk("t3_shift_err", {31'h0, er[1]}, 32'h0);
        chk("t3_full", {31'h0, ful[1]}, 32'h1);

        // Idle timeout and priority of clear
        cyc(1, 0, 0, 0, 4'h0, 0);
        key(4'h5);
        idle_n(15);
        chk("t4_pre", {31'h0, tmo[0]}, 32'h0);
        idle_n(1);
        chk("t4_timeout", {31'h0, tmo[0]}, 32'h1);
        chk("t4_len", {28'h0, clen[0]}, 32'h0);
        key(4'h7);
        cyc(1, 1, 0, 1, 4'h3, 0);
        chk("t4_clr_pri", {28'h0, clen[0]}, 32'h0);

        // HOLD ignores edits; reset between edges
        for (int i = 1; i <= 5; i++) key(4'(i));
        cyc(0, 1, 0, 0, 4'h0, 0);
        key(4'hA);
        cyc(0, 1, 1, 0, 4'h0, 0);
        chk("t5_hold", cout[0], 32'h0001_2345);
        #2 rst = 1'b1;
        #1;
        mreset();
        check_all();
        #1 rst = 1'b0;

        // Disabled timeout keeps entry
        cyc(1, 0, 0, 0, 4'h0, 0);
        key(4'h1);
        key(4'h2);
        idle_n(100);
        chk("t6_keep", cout[2], 32'h12);

        // Randomized traffic with periodic idle gaps
        for (int i = 0; i < 600; i++) begin
            int r;
            if (i % 150 == 149) idle_n(20);
            r = int'($urandom_range(0, 99));
            cyc(r < 3, r >= 3 && r < 11, r >= 11 && r < 20,
                r >= 20 && r < 70, 4'($urandom),
                $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
